cache_2way_wb: RTL and testbench

- 2-way set-associative, write-back, write-allocate data cache with LRU replacement, sitting between the CPU datapath and a 1 KiB byte-addressable main memory instantiated inside the block.
- Each rising clock edge processes one CPU request: a 32-bit word read or write at a 10-bit byte address.
- Reports hit/miss and the read word.

---
 rtl/cache_2way_wb_if.sv | 22 ++
 rtl/cache_2way_wb.sv | 104 ++++++++++
 tb/tb_cache_2way_wb.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cache_2way_wb_if.sv
// CPU-side request/response bundle for the 2-way write-back data cache.
// One request is presented per clock; the response is registered.
interface cache_2way_wb_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              read_write_from_cpu;
  logic [ADDR_W-1:0] address_from_cpu;
  logic [DATA_W-1:0] write_data_from_cpu;
  logic [DATA_W-1:0] read_data_out;
  logic              hit_miss_out;

  modport master (
    output read_write_from_cpu, address_from_cpu, write_data_from_cpu,
    input  read_data_out, hit_miss_out
  );

  modport slave (
    input  read_write_from_cpu, address_from_cpu, write_data_from_cpu,
    output read_data_out, hit_miss_out
  );
endinterface

// File: rtl/cache_2way_wb.sv
// 2-way set-associative, write-back, write-allocate cache with per-set LRU and an
// internal byte-addressed main memory; every request (hit or miss) completes in one cycle.
module cache_2way_wb #(
  parameter int ADDR_W          = 10,
  parameter int DATA_W          = 32,
  parameter int WORDS_PER_BLOCK = 4,
  parameter int NUM_SETS        = 2
) (
  input  logic           clk,
  input  logic           reset,
  cache_2way_wb_if.slave bus
);
  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int WORD_W = $clog2(WORDS_PER_BLOCK);
  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - SET_W - WORD_W - OFF_W;
  localparam int BYTES  = DATA_W / 8;

  logic [1:0]          valid_q [NUM_SETS];
  logic [1:0]          dirty_q [NUM_SETS];
  logic [NUM_SETS-1:0] lru_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS][2];
  logic [DATA_W-1:0]   data_q [NUM_SETS][2][WORDS_PER_BLOCK];
  logic [7:0]          mem    [2**ADDR_W] = '{default: 8'h00};

  logic [TAG_W-1:0]  tag;
  logic [SET_W-1:0]  set_idx;
  logic [WORD_W-1:0] word;
  logic [OFF_W-1:0]  addr_lsb_unused;
  logic              hit0, hit1, hit, way;
  logic [DATA_W-1:0] fill [WORDS_PER_BLOCK];

  assign {tag, set_idx, word, addr_lsb_unused} = bus.address_from_cpu;

  assign hit0 = valid_q[set_idx][0] && (tag_q[set_idx][0] == tag);
  assign hit1 = valid_q[set_idx][1] && (tag_q[set_idx][1] == tag);
  assign hit  = hit0 || hit1;

  // Victim preference on a miss: an empty way (way 0 first), otherwise the LRU way.
  always_comb begin
    way = lru_q[set_idx];
    if (hit0)                      way = 1'b0;
    else if (hit1)                 way = 1'b1;
    else if (!valid_q[set_idx][0]) way = 1'b0;
    else if (!valid_q[set_idx][1]) way = 1'b1;
  end

  always_comb begin
    fill = '{default: '0};
    for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
      for (int b = 0; b < BYTES; b++) begin
        fill[w][8*b +: 8] = mem[{tag, set_idx, WORD_W'(w), OFF_W'(b)}];
      end
    end
  end

  // Control state and registered response; cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q           <= '{default: '0};
      dirty_q           <= '{default: '0};
      lru_q             <= '0;
      bus.read_data_out <= '0;
      bus.hit_miss_out  <= 1'b0;
    end else begin
      valid_q[set_idx][way] <= 1'b1;
      if (bus.read_write_from_cpu)
        dirty_q[set_idx][way] <= 1'b1;
      else if (!hit)
        dirty_q[set_idx][way] <= 1'b0;
      lru_q[set_idx]   <= ~way;
      bus.hit_miss_out <= hit;
      if (bus.read_write_from_cpu)
        bus.read_data_out <= bus.write_data_from_cpu;
      else if (hit)
        bus.read_data_out <= data_q[set_idx][way][word];
      else
        bus.read_data_out <= fill[word];
    end
  end

  // Tags, block data and main memory carry no reset; a request seen while reset is high is dropped.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (!hit) begin
        if (valid_q[set_idx][way] && dirty_q[set_idx][way]) begin
          for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
            for (int b = 0; b < BYTES; b++) begin
              mem[{tag_q[set_idx][way], set_idx, WORD_W'(w), OFF_W'(b)}] <=
                data_q[set_idx][way][w][8*b +: 8];
            end
          end
        end
        tag_q[set_idx][way] <= tag;
        for (int w = 0; w < WORDS_PER_BLOCK; w++) begin
          data_q[set_idx][way][w] <= fill[w];
        end
      end
      // Later assignment overrides the filled word when a write misses.
      if (bus.read_write_from_cpu)
        data_q[set_idx][way][word] <= bus.write_data_from_cpu;
    end
  end
endmodule

// File: tb/tb_cache_2way_wb.sv
// Self-checking bench for cache_2way_wb: vector table fed through a response scoreboard,
// plus hand-written reset, write-back and memory-content sequences.
module tb_cache_2way_wb;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cache_2way_wb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  cache_2way_wb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WORDS_PER_BLOCK(4), .NUM_SETS(2))
    dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic        rw;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  typedef struct {
    logic        hit;
    logic [31:0] data;
    int          id;
  } exp_t;

  vec_t vecs [18];
  exp_t sb [$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h exp=%h", name, id, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [9:0] addr, input logic [31:0] wdata,
                       input logic hit, input logic [31:0] data, input int id);
    exp_t e;
    bus.read_write_from_cpu = rw;
    bus.address_from_cpu    = addr;
    bus.write_data_from_cpu = wdata;
    sb.push_back('{hit: hit, data: data, id: id});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty[%0d] got=0 exp=1", id);
    end else begin
      e = sb.pop_front();
      check("hit", e.id, {31'b0, bus.hit_miss_out}, {31'b0, e.hit});
      check("rdata", e.id, bus.read_data_out, e.data);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 10'h000, 32'h0,        1'b0, 32'h0000_0000};
    vecs[1]  = '{1'b1, 10'h000, 32'h0000_00FF, 1'b1, 32'h0000_00FF};
    vecs[2]  = '{1'b0, 10'h000, 32'h0,        1'b1, 32'h0000_00FF};
    vecs[3]  = '{1'b0, 10'h200, 32'h0,        1'b0, 32'h0000_0000};
    vecs[4]  = '{1'b0, 10'h000, 32'h0,        1'b1, 32'h0000_00FF};
    vecs[5]  = '{1'b0, 10'h300, 32'h0,        1'b0, 32'h0000_0000};
    vecs[6]  = '{1'b0, 10'h200, 32'h0,        1'b0, 32'h0000_0000};
    vecs[7]  = '{1'b1, 10'h01C, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF};
    vecs[8]  = '{1'b0, 10'h010, 32'h0,        1'b1, 32'h0000_0000};
    vecs[9]  = '{1'b0, 10'h01C, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vecs[10] = '{1'b1, 10'h3FC, 32'h1234_5678, 1'b0, 32'h1234_5678};
    vecs[11] = '{1'b0, 10'h01F, 32'h0,        1'b1, 32'hDEAD_BEEF};
    vecs[12] = '{1'b0, 10'h03C, 32'h0,        1'b0, 32'h0000_0000};
    vecs[13] = '{1'b0, 10'h3FC, 32'h0,        1'b0, 32'h1234_5678};
    vecs[14] = '{1'b0, 10'h3FC, 32'h0,        1'b1, 32'h1234_5678};
    vecs[15] = '{1'b0, 10'h3FC, 32'h0,        1'b1, 32'h1234_5678};
    vecs[16] = '{1'b1, 10'h3F8, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};
    vecs[17] = '{1'b1, 10'h3F8, 32'hA5A5_A5A5, 1'b1, 32'hA5A5_A5A5};

    bus.read_write_from_cpu = 1'b0;
    bus.address_from_cpu    = '0;
    bus.write_data_from_cpu = '0;
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_rdata", 0, bus.read_data_out, 32'h0);
    check("reset_hit", 0, {31'b0, bus.hit_miss_out}, 32'h0);
    check("reset_valid_s0", 0, {30'b0, dut.valid_q[0]}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].hit, vecs[i].data, i);
      if (i == 0) begin
        check("fill_valid_s0", i, {30'b0, dut.valid_q[0]}, 32'h1);
        check("fill_tag_s0w0", i, {27'b0, dut.tag_q[0][0]}, 32'h0);
      end
      if (i == 2) check("wb_mem0_clean", i, {24'b0, dut.mem[0]}, 32'h0);
      if (i == 6) begin
        check("evict_mem0", i, {24'b0, dut.mem[0]}, 32'hFF);
        check("evict_mem1", i, {24'b0, dut.mem[1]}, 32'h0);
        check("evict_mem2", i, {24'b0, dut.mem[2]}, 32'h0);
        check("evict_mem3", i, {24'b0, dut.mem[3]}, 32'h0);
      end
    end
    check("evict_mem3fc", 18, {24'b0, dut.mem[10'h3FC]}, 32'h78);
    check("evict_mem3ff", 18, {24'b0, dut.mem[10'h3FF]}, 32'h12);
    check("evict_mem01c", 18, {24'b0, dut.mem[10'h01C]}, 32'hEF);
    check("evict_mem01f", 18, {24'b0, dut.mem[10'h01F]}, 32'hDE);

    // A write presented when reset arrives must be dropped entirely.
    bus.read_write_from_cpu = 1'b1;
    bus.address_from_cpu    = 10'h000;
    bus.write_data_from_cpu = 32'h0000_0055;
    #2;
    reset = 1'b1;
    #1;
    check("async_rdata", 19, bus.read_data_out, 32'h0);
    check("async_hit", 19, {31'b0, bus.hit_miss_out}, 32'h0);
    @(posedge clk);
    #1;
    check("rst_valid_s0", 19, {30'b0, dut.valid_q[0]}, 32'h0);
    check("rst_valid_s1", 19, {30'b0, dut.valid_q[1]}, 32'h0);
    check("rst_mem0_kept", 19, {24'b0, dut.mem[0]}, 32'hFF);
    reset = 1'b0;
    drive(1'b0, 10'h000, 32'h0, 1'b0, 32'h0000_00FF, 20);
    drive(1'b0, 10'h000, 32'h0, 1'b1, 32'h0000_00FF, 21);

    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
